// File: rtl/cache_tag_array.sv
// N-way set-associative tag store with tree-PLRU, one-cycle registered lookup and single update port.
// Lookup result appears one cycle after acceptance; lookups and updates are refused while the invalidate sweep runs.
module cache_tag_array #(
   parameter  int WAYS  = 4,
   parameter  int SETS  = 512,
   parameter  int TAG_W = 20,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inv_all,
   output logic             busy,
   input  logic             lk_req,
   output logic             lk_ready,
   input  logic [IDX_W-1:0] lk_index,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [WAY_W-1:0] rsp_way,
   output logic [WAY_W-1:0] rsp_vict_way,
   output logic             rsp_vict_valid,
   output logic             rsp_vict_dirty,
   output logic [TAG_W-1:0] rsp_vict_tag,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_index,
   input  logic [WAY_W-1:0] upd_way,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic             upd_valid,
   input  logic             upd_dirty
);

   localparam int LVL   = $clog2(WAYS);
   localparam int NODES = WAYS - 1;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;

   logic [WAYS-1:0][TAG_W-1:0] tag_mem   [SETS];
   logic [WAYS-1:0]            vld_mem   [SETS];
   logic [WAYS-1:0]            dirty_mem [SETS];
   logic [NODES-1:0]           plru_mem  [SETS];

   logic [WAYS-1:0][TAG_W-1:0] rd_tag;
   logic [WAYS-1:0]            rd_vld;
   logic [WAYS-1:0]            rd_dirty;
   logic [NODES-1:0]           rd_plru;

   logic             lk_acc;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             any_inv;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] vict_way;

   // Node n (1-based heap order) lives at bit n-1; children are 2n and 2n+1.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] p,
                                                   input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      int               n;
      r = p;
      n = 1;
      for (int l = 0; l < LVL; l++) begin
         r[n-1] = ~way[LVL-1-l];
         n      = 2 * n + (way[LVL-1-l] ? 1 : 0);
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] p);
      int n;
      n = 1;
      for (int l = 0; l < LVL; l++) begin
         n = 2 * n + (p[n-1] ? 1 : 0);
      end
      return WAY_W'(n - WAYS);
   endfunction

   assign busy     = (state == SWEEP);
   assign lk_ready = ~busy;
   assign lk_acc   = lk_req & ~busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SWEEP;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (inv_all) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            if (inv_all) begin
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
            end
         end
         default: state_nxt = SWEEP;
      endcase
   end

   assign rd_tag   = tag_mem[lk_index];
   assign rd_vld   = vld_mem[lk_index];
   assign rd_dirty = dirty_mem[lk_index];
   assign rd_plru  = plru_mem[lk_index];

   // Descending scans so the lowest matching / lowest invalid way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_vld[w] && (rd_tag[w] == lk_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!rd_vld[w]) begin
            any_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
   end

   assign vict_way = any_inv ? inv_way : plru_victim(rd_plru);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid      <= 1'b0;
         rsp_hit        <= 1'b0;
         rsp_way        <= '0;
         rsp_vict_way   <= '0;
         rsp_vict_valid <= 1'b0;
         rsp_vict_dirty <= 1'b0;
         rsp_vict_tag   <= '0;
      end else begin
         rsp_valid <= lk_acc;
         if (lk_acc) begin
            rsp_hit        <= hit;
            rsp_way        <= hit_way;
            rsp_vict_way   <= vict_way;
            rsp_vict_valid <= rd_vld[vict_way];
            rsp_vict_dirty <= rd_vld[vict_way] & rd_dirty[vict_way];
            rsp_vict_tag   <= rd_tag[vict_way];
         end
      end
   end

   // Update's PLRU write is ordered after the lookup's so it wins on a shared set.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         vld_mem[cnt]   <= '0;
         dirty_mem[cnt] <= '0;
         plru_mem[cnt]  <= '0;
      end else begin
         if (lk_acc && hit) plru_mem[lk_index] <= plru_touch(rd_plru, hit_way);
         if (upd_en) begin
            tag_mem[upd_index][upd_way]   <= upd_tag;
            vld_mem[upd_index][upd_way]   <= upd_valid;
            dirty_mem[upd_index][upd_way] <= upd_dirty;
            if (upd_valid) plru_mem[upd_index] <= plru_touch(plru_mem[upd_index], upd_way);
         end
      end
   end

endmodule

// File: tb/tb_cache_tag_array.sv
module tb_cache_tag_array;

   localparam int WA = 4, SA = 16, TA = 20, IA = 4, WWA = 2;
   localparam int WB = 2, SB = 4,  TBW = 8, IB = 2, WWB = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           a_inv_all, a_busy, a_lk_req, a_lk_ready;
   logic [IA-1:0]  a_lk_index, a_upd_index;
   logic [TA-1:0]  a_lk_tag, a_rsp_vict_tag, a_upd_tag;
   logic           a_rsp_valid, a_rsp_hit, a_rsp_vict_valid, a_rsp_vict_dirty;
   logic [WWA-1:0] a_rsp_way, a_rsp_vict_way, a_upd_way;
   logic           a_upd_en, a_upd_valid, a_upd_dirty;

   logic           b_inv_all, b_busy, b_lk_req, b_lk_ready;
   logic [IB-1:0]  b_lk_index, b_upd_index;
   logic [TBW-1:0] b_lk_tag, b_rsp_vict_tag, b_upd_tag;
   logic           b_rsp_valid, b_rsp_hit, b_rsp_vict_valid, b_rsp_vict_dirty;
   logic [WWB-1:0] b_rsp_way, b_rsp_vict_way, b_upd_way;
   logic           b_upd_en, b_upd_valid, b_upd_dirty;

   cache_tag_array #(.WAYS(WA), .SETS(SA), .TAG_W(TA)) dut_a (
      .clk(clk), .rst(rst), .inv_all(a_inv_all), .busy(a_busy),
      .lk_req(a_lk_req), .lk_ready(a_lk_ready), .lk_index(a_lk_index), .lk_tag(a_lk_tag),
      .rsp_valid(a_rsp_valid), .rsp_hit(a_rsp_hit), .rsp_way(a_rsp_way),
      .rsp_vict_way(a_rsp_vict_way), .rsp_vict_valid(a_rsp_vict_valid),
      .rsp_vict_dirty(a_rsp_vict_dirty), .rsp_vict_tag(a_rsp_vict_tag),
      .upd_en(a_upd_en), .upd_index(a_upd_index), .upd_way(a_upd_way),
      .upd_tag(a_upd_tag), .upd_valid(a_upd_valid), .upd_dirty(a_upd_dirty));

   cache_tag_array #(.WAYS(WB), .SETS(SB), .TAG_W(TBW)) dut_b (
      .clk(clk), .rst(rst), .inv_all(b_inv_all), .busy(b_busy),
      .lk_req(b_lk_req), .lk_ready(b_lk_ready), .lk_index(b_lk_index), .lk_tag(b_lk_tag),
      .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_way(b_rsp_way),
      .rsp_vict_way(b_rsp_vict_way), .rsp_vict_valid(b_rsp_vict_valid),
      .rsp_vict_dirty(b_rsp_vict_dirty), .rsp_vict_tag(b_rsp_vict_tag),
      .upd_en(b_upd_en), .upd_index(b_upd_index), .upd_way(b_upd_way),
      .upd_tag(b_upd_tag), .upd_valid(b_upd_valid), .upd_dirty(b_upd_dirty));

   typedef struct {
      int due;
      bit hit;
      int way;
      int vway;
      bit vv;
      bit vd;
      int vtag;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model for the 4-way instance: plain arrays, PLRU walked by range halving.
   bit [TA-1:0] m_tag [SA][WA];
   bit          m_val [SA][WA];
   bit          m_dir [SA][WA];
   bit          m_node[SA][WA];
   int          sweep_pos;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void m_touch(input int s, input int w);
      int n = 0, lo = 0, hi = WA, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin m_node[s][n] = 1'b1; n = 2 * n + 1; hi = mid; end
         else         begin m_node[s][n] = 1'b0; n = 2 * n + 2; lo = mid; end
      end
   endfunction

   function automatic int m_victim(input int s);
      int n = 0, lo = 0, hi = WA, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (m_node[s][n]) begin lo = mid; n = 2 * n + 2; end
         else              begin hi = mid; n = 2 * n + 1; end
      end
      return lo;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
         ea = qa.pop_front();
         check("a_rsp_valid", a_rsp_valid, 1);
         if (a_rsp_valid) begin
            check("a_rsp_hit", a_rsp_hit, ea.hit);
            check("a_rsp_way", a_rsp_way, ea.way);
            check("a_vict_way", a_rsp_vict_way, ea.vway);
            check("a_vict_valid", a_rsp_vict_valid, ea.vv);
            check("a_vict_dirty", a_rsp_vict_dirty, ea.vd);
            if (ea.vv) check("a_vict_tag", a_rsp_vict_tag, ea.vtag);
         end
      end else begin
         check("a_rsp_valid_idle", a_rsp_valid, 0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
         eb = qb.pop_front();
         check("b_rsp_valid", b_rsp_valid, 1);
         if (b_rsp_valid) begin
            check("b_rsp_hit", b_rsp_hit, eb.hit);
            check("b_rsp_way", b_rsp_way, eb.way);
            check("b_vict_way", b_rsp_vict_way, eb.vway);
            check("b_vict_valid", b_rsp_vict_valid, eb.vv);
            check("b_vict_tag", b_rsp_vict_tag, eb.vtag);
         end
      end else begin
         check("b_rsp_valid_idle", b_rsp_valid, 0);
      end
   end

   task automatic clear_inputs();
      a_inv_all = 0; a_lk_req = 0; a_upd_en = 0;
      a_lk_index = '0; a_lk_tag = '0; a_upd_index = '0; a_upd_way = '0;
      a_upd_tag = '0; a_upd_valid = 0; a_upd_dirty = 0;
      b_inv_all = 0; b_lk_req = 0; b_upd_en = 0;
      b_lk_index = '0; b_lk_tag = '0; b_upd_index = '0; b_upd_way = '0;
      b_upd_tag = '0; b_upd_valid = 0; b_upd_dirty = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      qa.delete();
      qb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      sweep_pos = 0;
   endtask

   task automatic a_set_lk(input int idx, input int tag);
      a_lk_req = 1; a_lk_index = IA'(idx); a_lk_tag = TA'(tag);
   endtask

   task automatic a_set_upd(input int idx, input int way, input int tag, input bit v, input bit d);
      a_upd_en = 1; a_upd_index = IA'(idx); a_upd_way = WWA'(way);
      a_upd_tag = TA'(tag); a_upd_valid = v; a_upd_dirty = d;
   endtask

   // Called at posedge+1 with inputs set; advances the model one clock and the DUT one edge.
   task automatic a_cycle();
      exp_t e;
      bit   busy_m;
      bit   saved[WA];
      int   s, ui, uw;
      busy_m = (sweep_pos < SA);
      check("a_busy", a_busy, busy_m);
      check("a_lk_ready", a_lk_ready, !busy_m);
      if (!busy_m) begin
         ui = int'(a_upd_index);
         uw = int'(a_upd_way);
         for (int k = 0; k < WA; k++) saved[k] = m_node[ui][k];
         if (a_lk_req) begin
            s = int'(a_lk_index);
            e.due = cyc + 1; e.hit = 0; e.way = 0; e.vway = -1;
            for (int w = 0; w < WA; w++) begin
               if (!e.hit && m_val[s][w] && m_tag[s][w] == a_lk_tag) begin e.hit = 1; e.way = w; end
               if (e.vway < 0 && !m_val[s][w]) e.vway = w;
            end
            if (e.vway < 0) begin e.vway = m_victim(s); e.vv = 1; end
            else e.vv = 0;
            e.vd   = m_val[s][e.vway] && m_dir[s][e.vway];
            e.vtag = int'(m_tag[s][e.vway]);
            qa.push_back(e);
            if (e.hit) m_touch(s, e.way);
         end
         if (a_upd_en) begin
            m_tag[ui][uw] = a_upd_tag;
            m_val[ui][uw] = a_upd_valid;
            m_dir[ui][uw] = a_upd_dirty;
            if (a_upd_valid) begin
               for (int k = 0; k < WA; k++) m_node[ui][k] = saved[k];
               m_touch(ui, uw);
            end
         end
      end else begin
         for (int k = 0; k < WA; k++) begin
            m_val[sweep_pos][k] = 0; m_dir[sweep_pos][k] = 0; m_node[sweep_pos][k] = 0;
         end
      end
      if (a_inv_all) sweep_pos = 0;
      else if (busy_m) sweep_pos++;
      @(posedge clk);
      #1;
      a_lk_req = 0; a_upd_en = 0; a_inv_all = 0;
   endtask

   task automatic count_busy(input string nm, input int want);
      int nb = 0;
      while (a_busy && nb < 100) begin a_cycle(); nb++; end
      check(nm, nb, want);
   endtask

   task automatic b_cycle();
      @(posedge clk);
      #1;
      b_lk_req = 0; b_upd_en = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int last, w;
      clear_inputs();
      do_reset();
      count_busy("busy_after_reset", SA);

      a_set_lk(3, 'h12345); a_cycle();

      for (int k = 0; k < WA; k++) begin
         a_set_upd(5, k, 'hA0 + k, 1, k == 2); a_cycle();
      end
      a_set_lk(5, 'hA1); a_cycle();
      a_set_lk(5, 'hA3); a_cycle();
      a_set_lk(5, 'hA0); a_cycle();
      a_set_lk(5, 'hBEEF); a_cycle();

      a_set_upd(7, 1, 'h55, 1, 0); a_set_lk(7, 'h55); a_cycle();
      a_set_lk(7, 'h55); a_cycle();

      a_inv_all = 1; a_cycle();
      repeat (8) a_cycle();
      a_inv_all = 1; a_cycle();
      count_busy("busy_after_restart", SA);
      a_set_lk(5, 'hA1); a_cycle();

      a_set_lk(2, 'h1); a_cycle();
      a_set_upd(9, 0, 'h77, 1, 1); a_set_lk(9, 'h77);
      do_reset();
      a_set_upd(9, 0, 'h77, 1, 1); a_cycle();
      count_busy("busy_after_midreset", SA - 1);
      a_set_lk(9, 'h77); a_cycle();

      for (int i = 0; i < 500; i++) begin
         if ($urandom % 4 != 0) a_set_lk($urandom % 3, 'h100 + $urandom % 5);
         if ($urandom % 3 == 0)
            a_set_upd($urandom % 3, $urandom % WA, 'h100 + $urandom % 5,
                      ($urandom % 4) != 0, $urandom % 2);
         if ($urandom % 150 == 0) a_inv_all = 1;
         a_cycle();
      end
      while (sweep_pos < SA) a_cycle();
      repeat (3) a_cycle();

      b_upd_en = 1; b_upd_index = 1; b_upd_way = 0; b_upd_tag = 'h10; b_upd_valid = 1; b_cycle();
      b_upd_en = 1; b_upd_index = 1; b_upd_way = 1; b_upd_tag = 'h11; b_upd_valid = 1; b_cycle();
      last = 1;
      for (int k = 0; k < 16; k++) begin
         w = (k < 8) ? (k % 2) : int'($urandom % 2);
         b_lk_req = 1; b_lk_index = 1; b_lk_tag = TBW'('h10 + w);
         eb.due = cyc + 1; eb.hit = 1; eb.way = w; eb.vway = 1 - last; eb.vv = 1;
         eb.vd = 0; eb.vtag = 'h10 + (1 - last);
         qb.push_back(eb);
         last = w;
         b_cycle();
      end
      repeat (3) b_cycle();

      check("qa_drained", qa.size(), 0);
      check("qb_drained", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
